// File: rtl/layer_address_generator_pkg.sv
// Shared definitions for the fully-connected layer address generator:
// FSM encodings (also used by control-unit monitors) and default sizing.
package layer_address_generator_pkg;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ag_state_e;

  localparam int unsigned DEF_ADDR_W     = 8;
  localparam int unsigned DEF_N_INPUTS   = 4;
  localparam int unsigned DEF_N_NEURONS  = 3;
  localparam int unsigned DEF_RD_LATENCY = 2;

  function automatic logic is_busy_state(input ag_state_e s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/layer_address_generator_valid_delay_pipe.sv
// Fixed-depth shift register carrying {valid, last} alongside synchronous
// memory reads; it never stalls and is flushed by a synchronous clear.
module layer_address_generator_valid_delay_pipe
  import layer_address_generator_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_RD_LATENCY
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [1:0] tag,
  output logic [1:0] tag_dly
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("valid delay pipe DEPTH must be at least 1");
  end

  logic [1:0] stage_r [DEPTH];

  // Shift one stage per clock; clear drops every beat in flight.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= 2'b00;
      end
    end else begin
      stage_r[0] <= tag;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign tag_dly = stage_r[DEPTH-1];

endmodule

// File: rtl/layer_address_generator.sv
// Address generator for one fully-connected layer: walks (neuron, input)
// pairs on AG_read, tracks read latency and reports layer completion.
module layer_address_generator
  import layer_address_generator_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned N_INPUTS   = DEF_N_INPUTS,
  parameter int unsigned N_NEURONS  = DEF_N_NEURONS,
  parameter int unsigned RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              AG_rst,
  input  logic              AG_read,
  output logic [ADDR_W-1:0] weight_addr,
  output logic [ADDR_W-1:0] input_addr,
  output logic [ADDR_W-1:0] neuron_idx,
  output logic              addr_valid,
  output logic              data_valid,
  output logic              last_input,
  output logic              layer_done,
  output logic              busy
);

  localparam longint unsigned PAIRS     = 64'(N_NEURONS) * 64'(N_INPUTS);
  localparam longint unsigned ADDR_SPAN = 64'd1 << ADDR_W;

  if (PAIRS > ADDR_SPAN) begin : g_bad_span
    $error("N_NEURONS*N_INPUTS exceeds the address space of ADDR_W");
  end
  if (N_INPUTS < 1 || N_NEURONS < 1 || RD_LATENCY < 1) begin : g_bad_size
    $error("N_INPUTS, N_NEURONS and RD_LATENCY must all be at least 1");
  end

  localparam logic [ADDR_W-1:0] LAST_IN  = ADDR_W'(N_INPUTS - 1);
  localparam logic [ADDR_W-1:0] LAST_NEU = ADDR_W'(N_NEURONS - 1);

  ag_state_e         state_r;
  ag_state_e         state_next_s;
  logic              issue_s;
  logic              final_pair_s;
  logic              final_beat_s;
  logic              clear_s;

  // Next pair to issue; the output registers hold the last issued pair.
  logic [ADDR_W-1:0] cnt_in_r;
  logic [ADDR_W-1:0] cnt_neu_r;
  logic [ADDR_W-1:0] cnt_w_r;
  logic [ADDR_W-1:0] last_cnt_r;

  logic [ADDR_W-1:0] weight_addr_r;
  logic [ADDR_W-1:0] input_addr_r;
  logic [ADDR_W-1:0] neuron_idx_r;
  logic              addr_valid_r;
  logic              addr_last_r;
  logic              layer_done_r;
  logic              busy_r;
  logic [1:0]        pipe_in_s;
  logic [1:0]        pipe_out_s;

  assign clear_s      = reset | AG_rst;
  assign final_pair_s = (cnt_in_r == LAST_IN) && (cnt_neu_r == LAST_NEU);
  // Only last-tagged beats advance last_cnt_r, so the N_NEURONS-th one is final.
  assign final_beat_s = pipe_out_s[1] & pipe_out_s[0] & (last_cnt_r == LAST_NEU);
  assign pipe_in_s    = {addr_valid_r, addr_last_r};

  // Next-state and issue decode.
  always_comb begin
    state_next_s = state_r;
    issue_s      = 1'b0;
    case (state_r)
      ST_READY: begin
        if (AG_read) begin
          issue_s      = 1'b1;
          state_next_s = final_pair_s ? ST_DRAIN : ST_RUN;
        end else begin
          state_next_s = ST_READY;
        end
      end
      ST_RUN: begin
        if (AG_read) begin
          issue_s      = 1'b1;
          state_next_s = final_pair_s ? ST_DRAIN : ST_RUN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (final_beat_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_next_s = ST_DONE;
      end
      default: begin
        state_next_s = ST_READY;
      end
    endcase
  end

  // State, pair counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset || AG_rst) begin
      state_r       <= ST_READY;
      cnt_in_r      <= {ADDR_W{1'b0}};
      cnt_neu_r     <= {ADDR_W{1'b0}};
      cnt_w_r       <= {ADDR_W{1'b0}};
      last_cnt_r    <= {ADDR_W{1'b0}};
      weight_addr_r <= {ADDR_W{1'b0}};
      input_addr_r  <= {ADDR_W{1'b0}};
      neuron_idx_r  <= {ADDR_W{1'b0}};
      addr_valid_r  <= 1'b0;
      addr_last_r   <= 1'b0;
      layer_done_r  <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      addr_valid_r <= issue_s;
      addr_last_r  <= issue_s & (cnt_in_r == LAST_IN);
      layer_done_r <= (state_next_s == ST_DONE);
      busy_r       <= is_busy_state(state_next_s);
      if (issue_s) begin
        weight_addr_r <= cnt_w_r;
        input_addr_r  <= cnt_in_r;
        neuron_idx_r  <= cnt_neu_r;
        cnt_w_r       <= cnt_w_r + ADDR_W'(1);
        if (cnt_in_r == LAST_IN) begin
          cnt_in_r  <= {ADDR_W{1'b0}};
          cnt_neu_r <= cnt_neu_r + ADDR_W'(1);
        end else begin
          cnt_in_r  <= cnt_in_r + ADDR_W'(1);
        end
      end
      if (pipe_out_s[1] & pipe_out_s[0]) begin
        last_cnt_r <= last_cnt_r + ADDR_W'(1);
      end
    end
  end

  layer_address_generator_valid_delay_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_valid_pipe (
    .clk     (clk),
    .clear   (clear_s),
    .tag     (pipe_in_s),
    .tag_dly (pipe_out_s)
  );

  assign weight_addr = weight_addr_r;
  assign input_addr  = input_addr_r;
  assign neuron_idx  = neuron_idx_r;
  assign addr_valid  = addr_valid_r;
  assign data_valid  = pipe_out_s[1];
  assign last_input  = pipe_out_s[0];
  assign layer_done  = layer_done_r;
  assign busy        = busy_r;

endmodule
